// File: rtl/mem_burst_seq.sv
// mem_burst_seq: multi-beat load/store sequencer between a register file and a word memory.
// Load data returns one cycle after its read strobe, so loads spend one extra DRAIN cycle.
module mem_burst_seq #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 7,
   parameter int REG_W     = 5,
   parameter int MAX_BEATS = 2,
   localparam int CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_store,
   input  logic [CNT_W-1:0]  beats_m1,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [REG_W-1:0]  base_reg,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic [DATA_W-1:0] ReadDataMem,
   output logic [REG_W-1:0]  reg_ridx,
   output logic              reg_we,
   output logic [REG_W-1:0]  reg_widx,
   output logic [DATA_W-1:0] reg_wdata,
   output logic [ADDR_W-1:0] A,
   output logic              CEN,
   output logic              WEN,
   output logic              OEN,
   output logic [DATA_W-1:0] Data2Mem,
   output logic              hold_pc,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  k_q, k_d, bm1_q, bm1_d;
   logic              st_q, st_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [REG_W-1:0]  reg_q, reg_d, widx_q, widx_d, ridx_k;
   logic              idle, issue, last;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         bm1_q   <= '0;
         st_q    <= 1'b0;
         addr_q  <= '0;
         reg_q   <= '0;
         we_q    <= 1'b0;
         widx_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         bm1_q   <= bm1_d;
         st_q    <= st_d;
         addr_q  <= addr_d;
         reg_q   <= reg_d;
         we_q    <= we_d;
         widx_q  <= widx_d;
      end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      bm1_d   = bm1_q;
      st_d    = st_q;
      addr_d  = addr_q;
      reg_d   = reg_q;
      idle    = state_q == IDLE;
      issue   = state_q == ISSUE;
      last    = k_q == bm1_q;
      ridx_k  = reg_q + REG_W'(k_q);
      // a load beat issued now is written back from the registered index next cycle
      we_d    = issue && !st_q;
      widx_d  = ridx_k;
      if (idle && start) begin
         state_d = ISSUE;
         k_d     = '0;
         bm1_d   = beats_m1;
         st_d    = is_store;
         addr_d  = base_addr;
         reg_d   = base_reg;
      end else if (issue) begin
         state_d = last ? (st_q ? IDLE : DRAIN) : ISSUE;
         k_d     = last ? k_q : k_q + CNT_W'(1);
      end else if (state_q == DRAIN) begin
         state_d = IDLE;
      end
      CEN      = !issue;
      WEN      = !(issue && st_q);
      OEN      = !(issue && !st_q);
      A        = idle ? base_addr : addr_q + ADDR_W'(k_q);
      reg_ridx = idle ? base_reg : ridx_k;
      done     = (issue && last && st_q) || state_q == DRAIN;
      hold_pc  = idle ? start : !done;
   end

   assign reg_we    = we_q;
   assign reg_widx  = widx_q;
   assign reg_wdata = ReadDataMem;
   assign Data2Mem  = reg_rdata;
endmodule

// File: tb/tb_mem_burst_seq.sv
// tb_mem_burst_seq: scoreboard bench for mem_burst_seq with memory and register-file models.
module tb_mem_burst_seq;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start_a, st_a;
   logic [1:0]  bm1_a;
   logic [6:0]  ba_a, a_a;
   logic [4:0]  br_a, ridx_a, widx_a;
   logic [31:0] rrd_a, rdm_a, wdata_a, d2m_a;
   logic        we_a, cen_a, wen_a, oen_a, hold_a, done_a;

   logic        start_b, st_b;
   logic [0:0]  bm1_b;
   logic [6:0]  ba_b, a_b;
   logic [4:0]  br_b, ridx_b, widx_b;
   logic [31:0] wdata_b, d2m_b;
   logic        we_b, cen_b, wen_b, oen_b, hold_b, done_b;

   mem_burst_seq #(.MAX_BEATS(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .is_store(st_a), .beats_m1(bm1_a),
      .base_addr(ba_a), .base_reg(br_a), .reg_rdata(rrd_a), .ReadDataMem(rdm_a),
      .reg_ridx(ridx_a), .reg_we(we_a), .reg_widx(widx_a), .reg_wdata(wdata_a),
      .A(a_a), .CEN(cen_a), .WEN(wen_a), .OEN(oen_a), .Data2Mem(d2m_a),
      .hold_pc(hold_a), .done(done_a));

   mem_burst_seq #(.MAX_BEATS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .is_store(st_b), .beats_m1(bm1_b),
      .base_addr(ba_b), .base_reg(br_b), .reg_rdata(32'h55), .ReadDataMem(32'h66),
      .reg_ridx(ridx_b), .reg_we(we_b), .reg_widx(widx_b), .reg_wdata(wdata_b),
      .A(a_b), .CEN(cen_b), .WEN(wen_b), .OEN(oen_b), .Data2Mem(d2m_b),
      .hold_pc(hold_b), .done(done_b));

   function automatic logic [31:0] memf(input int i);
      return i == 5 ? 32'hA : i == 6 ? 32'hB : 32'h1000 + i;
   endfunction
   function automatic logic [31:0] rff(input int i);
      return i == 2 ? 32'h11 : i == 3 ? 32'h22 : 32'h200 + i;
   endfunction

   logic        ready;
   logic [31:0] mem [128];
   logic [31:0] rf [32];
   logic [31:0] emem [128];
   logic [31:0] erf [32];
   logic [49:0] q [$];
   int          n_chk = 0, n_fail = 0;

   always @(posedge clk)
      if (!ready) begin
         for (int i = 0; i < 128; i++) mem[i] <= memf(i);
      end else begin
         if (!cen_a && !wen_a) mem[a_a] <= d2m_a;
         if (!cen_a && !oen_a) rdm_a <= mem[a_a];
      end

   always @(posedge clk)
      if (!ready) begin
         for (int i = 0; i < 32; i++) rf[i] <= rff(i);
      end else if (we_a) begin
         rf[widx_a] <= wdata_a;
      end

   assign rrd_a = rf[ridx_a];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // unused fields are zeroed so don't-care outputs never cause a miscompare
   function automatic logic [49:0] pk(input logic [6:0] a, input logic cen, wen, oen, we,
                                      input logic [4:0] wi, input logic [31:0] wd,
                                      input logic dn, hd);
      return {cen ? 7'd0 : a, cen, wen, oen, we, we ? wi : 5'd0, we ? wd : 32'd0, dn, hd};
   endfunction

   always @(negedge clk)
      if (q.size() > 0)
         chk("beat", pk(a_a, cen_a, wen_a, oen_a, we_a, widx_a, wdata_a, done_a, hold_a),
             q.pop_front());

   task automatic wait_empty(input string tag);
      int t = 0;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (q.size() != 0) begin
         chk(tag, 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   task automatic burst(input logic st, input int n, input logic [6:0] ba,
                        input logic [4:0] br, input logic keep);
      logic [6:0] ak, ap;
      logic [4:0] rk, rp;
      int         busy;
      busy = st ? n : n + 1;
      wait_empty("pre_timeout");
      @(posedge clk); #1;
      start_a = 1'b1; st_a = st; bm1_a = 2'(n - 1); ba_a = ba; br_a = br;
      q.push_back(pk(ba, 1, 1, 1, 0, 0, 0, 0, 1));
      for (int k = 0; k < n; k++) begin
         ak = ba + 7'(k); ap = ba + 7'(k - 1);
         rk = br + 5'(k); rp = br + 5'(k - 1);
         q.push_back(pk(ak, 0, !st, st, !st && k > 0, rp, emem[ap],
                        st && k == n - 1, !(st && k == n - 1)));
         if (st) emem[ak] = erf[rk];
         else if (k > 0) erf[rp] = emem[ap];
      end
      if (!st) begin
         ap = ba + 7'(n - 1); rp = br + 5'(n - 1);
         q.push_back(pk(0, 1, 1, 1, 1, rp, emem[ap], 1, 0));
         erf[rp] = emem[ap];
      end
      q.push_back(pk(0, 1, 1, 1, 0, 0, 0, 0, 0));
      repeat (keep ? busy + 1 : 1) @(posedge clk);
      #1 start_a = 1'b0;
      wait_empty("burst_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 128; i++) emem[i] = memf(i);
      for (int i = 0; i < 32; i++) erf[i] = rff(i);
      ready = 1'b0; rst_n = 1'b0;
      start_a = 0; st_a = 0; bm1_a = 0; ba_a = 7'd33; br_a = 5'd9;
      start_b = 0; st_b = 0; bm1_b = 0; ba_b = 7'd9; br_b = 5'd3;
      #3;
      chk("rst_strobes", {cen_a, wen_a, oen_a, we_a, done_a, hold_a}, 6'b111000);
      chk("rst_idle_a", a_a, 7'd33);
      chk("rst_idle_ridx", ridx_a, 5'd9);
      start_a = 1'b1; #1;
      chk("rst_hold_start", hold_a, 1'b1);
      start_a = 1'b0;
      repeat (2) @(posedge clk);
      #1 ready = 1'b1; rst_n = 1'b1;

      burst(0, 2, 7'd5, 5'd4, 0);
      burst(1, 2, 7'd10, 5'd2, 0);
      burst(0, 4, 7'd126, 5'd30, 0);
      burst(1, 4, 7'd125, 5'd29, 1);
      burst(0, 1, 7'd0, 5'd7, 1);
      burst(1, 3, 7'd40, 5'd4, 0);

      // reset during load beat 1 aborts the burst
      @(posedge clk); #1;
      start_a = 1'b1; st_a = 1'b0; bm1_a = 2'd1; ba_a = 7'd20; br_a = 5'd12;
      q.push_back(pk(20, 1, 1, 1, 0, 0, 0, 0, 1));
      q.push_back(pk(20, 0, 1, 0, 0, 0, 0, 0, 1));
      @(posedge clk); #1 start_a = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("abort_strobes", {cen_a, wen_a, oen_a, we_a, done_a, hold_a}, 6'b111000);
      start_a = 1'b1; #1;
      chk("abort_hold", hold_a, 1'b1);
      start_a = 1'b0;
      @(negedge clk);
      chk("abort_no_we", {we_a, cen_a}, 2'b01);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_idle", {cen_a, oen_a, we_a, done_a, hold_a}, 5'b11000);
      @(negedge clk);
      chk("abort_idle2", {cen_a, we_a}, 2'b10);

      // single-beat configuration
      @(posedge clk); #1 start_b = 1'b1; st_b = 1'b0;
      @(negedge clk);
      chk("b_ld_c0", {cen_b, hold_b}, 2'b11);
      @(posedge clk); #1 start_b = 1'b0;
      @(negedge clk);
      chk("b_ld_issue", {cen_b, oen_b, wen_b, done_b, hold_b}, 5'b00101);
      chk("b_ld_addr", a_b, 7'd9);
      @(negedge clk);
      chk("b_ld_drain", {cen_b, oen_b, we_b, done_b, hold_b}, 5'b11110);
      chk("b_ld_wdata", {widx_b, wdata_b}, {5'd3, 32'h66});
      @(negedge clk);
      chk("b_ld_idle", {cen_b, we_b, done_b, hold_b}, 4'b1000);
      @(posedge clk); #1 start_b = 1'b1; st_b = 1'b1; ba_b = 7'd127; br_b = 5'd31;
      @(posedge clk); #1 start_b = 1'b0;
      @(negedge clk);
      chk("b_st_issue", {cen_b, wen_b, oen_b, we_b, done_b, hold_b}, 6'b001010);
      chk("b_st_data", {a_b, ridx_b, d2m_b}, {7'd127, 5'd31, 32'h55});
      @(negedge clk);
      chk("b_st_idle", {cen_b, wen_b, we_b, done_b, hold_b}, 5'b11000);

      for (int i = 0; i < 128; i++) chk($sformatf("mem%0d", i), mem[i], emem[i]);
      for (int i = 0; i < 32; i++) chk($sformatf("r%0d", i), rf[i], erf[i]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
